branch_target_buffer: RTL and testbench

Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters. It sits beside the fetch-stage PC register. Each cycle it turns the fetch PC into a predicted next PC, and it is trained by branch/jump resolution from the execute stage. This lets taken branches redirect fetch without waiting for the EX-stage resolution and its IF/ID flush. It also keeps a saturating mispredict counter for performance checks.

---
 rtl/branch_target_buffer.sv | 86 ++++++++
 tb/tb_branch_target_buffer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with saturating direction counters and a mispredict counter
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [31:0]      lookup_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_npc,
    input  logic             update_en,
    input  logic [31:0]      update_pc,
    input  logic             update_taken,
    input  logic [31:0]      update_target,
    input  logic             update_mispred,
    input  logic             invalidate_all,
    output logic [CNT_W-1:0] mispred_count
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [31:0]        target [ENTRIES];
    logic [CTR_W-1:0]   ctr    [ENTRIES];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             u_hit;
    logic             unused_bits;

    assign l_idx       = lookup_pc[IDX_W+1:2];
    assign l_tag       = lookup_pc[31:IDX_W+2];
    assign u_idx       = update_pc[IDX_W+1:2];
    assign u_tag       = update_pc[31:IDX_W+2];
    assign unused_bits = ^update_pc[1:0];

    // combinational lookup against current (pre-update) contents
    always_comb begin
        pred_hit   = valid[l_idx] && (tag_q[l_idx] == l_tag);
        pred_taken = pred_hit && ctr[l_idx][CTR_W-1];
        pred_npc   = pred_taken ? target[l_idx] : lookup_pc + 32'd4;
        u_hit      = valid[u_idx] && (tag_q[u_idx] == u_tag);
    end

    // training: hit adjusts counter/target, taken miss allocates, invalidate overrides valid bits
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]  <= '0;
                target[i] <= '0;
                ctr[i]    <= '0;
            end
        end else begin
            if (update_en && u_hit) begin
                if (update_taken) begin
                    ctr[u_idx]    <= (ctr[u_idx] == CTR_MAX) ? CTR_MAX : ctr[u_idx] + 1'b1;
                    target[u_idx] <= update_target;
                end else begin
                    ctr[u_idx] <= (ctr[u_idx] == '0) ? '0 : ctr[u_idx] - 1'b1;
                end
            end else if (update_en && update_taken) begin
                valid[u_idx]  <= 1'b1;
                tag_q[u_idx]  <= u_tag;
                target[u_idx] <= update_target;
                ctr[u_idx]    <= CTR_WEAK;
            end
            if (invalidate_all)
                valid <= '0;
        end
    end

    // saturating count of mispredicted resolutions
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            mispred_count <= '0;
        else if (update_en && update_mispred && mispred_count != CNT_MAX)
            mispred_count <= mispred_count + 1'b1;
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: table-driven directed checks of the BTB plus counter saturation and async reset
module tb_branch_target_buffer;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] lookup_pc = 32'h40;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_npc;
    logic        update_en = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = '0;
    logic        update_mispred = 1'b0;
    logic        invalidate_all = 1'b0;
    logic [3:0]  mispred_count;

    int checks = 0;
    int failures = 0;

    branch_target_buffer #(.ENTRIES(16), .CTR_W(2), .CNT_W(4)) dut (
        .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_npc(pred_npc),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispred(update_mispred),
        .invalidate_all(invalidate_all), .mispred_count(mispred_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] lpc;
        logic        ue;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        um;
        logic        inv;
        logic        eh;
        logic        et;
        logic [31:0] enpc;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [31:0] lpc, input logic ue, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utg, input logic um, input logic inv,
                       input logic eh, input logic et, input logic [31:0] enpc, input logic [3:0] ecnt);
        vec_t v;
        v = '{lpc, ue, upc, ut, utg, um, inv, eh, et, enpc, ecnt};
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        update_en = 1'b0;
        update_taken = 1'b0;
        update_mispred = 1'b0;
        invalidate_all = 1'b0;
    endtask

    initial begin
        // lookup_pc, ue, update_pc, ut, target, um, inv | hit, taken, npc, cnt (seen before the edge)
        add(32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h44,  0);  // reset state
        add(32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 0, 0, 32'h44,  0);  // allocate, no bypass
        add(32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 1, 1, 32'h100, 0);
        add(32'h80, 0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h84,  0);  // alias tag miss
        add(32'h40, 1, 32'h40, 0, 32'h0,   1, 0, 1, 1, 32'h100, 0);  // 10 -> 01
        add(32'h40, 1, 32'h40, 0, 32'h0,   0, 0, 1, 0, 32'h44,  1);  // 01 -> 00
        add(32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 1, 0, 32'h44,  1);  // 00 -> 01
        add(32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 1, 0, 32'h44,  1);  // 01 -> 10
        add(32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 1, 1, 32'h100, 1);  // 10 -> 11
        add(32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 1, 1, 32'h100, 1);  // stays 11
        add(32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 1, 1, 32'h100, 1);  // stays 11
        add(32'h40, 1, 32'h40, 0, 32'h0,   0, 0, 1, 1, 32'h100, 1);  // 11 -> 10
        add(32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 1, 1, 32'h100, 1);  // still taken
        add(32'h40, 1, 32'h80, 1, 32'h200, 0, 0, 1, 1, 32'h100, 1);  // evict via alias
        add(32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h44,  1);
        add(32'h80, 0, 32'h0,  0, 32'h0,   0, 0, 1, 1, 32'h200, 1);
        add(32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1); // npc wrap
        add(32'h84, 1, 32'h84, 1, 32'h300, 0, 0, 0, 0, 32'h88,  1);
        add(32'h84, 1, 32'h84, 1, 32'h340, 0, 0, 1, 1, 32'h300, 1);  // retarget on hit
        add(32'h84, 0, 32'h0,  0, 32'h0,   0, 0, 1, 1, 32'h340, 1);
        add(32'h84, 1, 32'h44, 1, 32'h500, 1, 1, 1, 1, 32'h340, 1);  // invalidate beats update
        add(32'h84, 0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h88,  2);
        add(32'h44, 0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h48,  2);
        add(32'h80, 0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h84,  2);
        add(32'h48, 1, 32'h48, 0, 32'h600, 0, 0, 0, 0, 32'h4C,  2);  // miss not-taken: no alloc
        add(32'h48, 0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h4C,  2);

        #12 nRST = 1'b1;
        foreach (vq[i]) begin
            @(negedge CLK);
            lookup_pc = vq[i].lpc;
            update_en = vq[i].ue;
            update_pc = vq[i].upc;
            update_taken = vq[i].ut;
            update_target = vq[i].utg;
            update_mispred = vq[i].um;
            invalidate_all = vq[i].inv;
            #2;
            chk($sformatf("v%0d hit", i), {31'd0, pred_hit}, {31'd0, vq[i].eh});
            chk($sformatf("v%0d taken", i), {31'd0, pred_taken}, {31'd0, vq[i].et});
            chk($sformatf("v%0d npc", i), pred_npc, vq[i].enpc);
            chk($sformatf("v%0d cnt", i), {28'd0, mispred_count}, {28'd0, vq[i].ecnt});
        end

        // mispredict counter saturation: starts at 2, 20 more mispredicts must stop at 15
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            update_en = 1'b1;
            update_pc = 32'h1000;
            update_taken = 1'b0;
            update_mispred = 1'b1;
            invalidate_all = 1'b0;
            if (n == 13) begin
                #2 chk("cnt at 15", {28'd0, mispred_count}, 32'd15);
            end
        end
        @(negedge CLK);
        idle();
        #2 chk("cnt saturated", {28'd0, mispred_count}, 32'd15);

        // allocate an entry, then assert reset between edges while an update is pending
        @(negedge CLK);
        update_en = 1'b1;
        update_pc = 32'h40;
        update_taken = 1'b1;
        update_target = 32'h100;
        @(negedge CLK);
        lookup_pc = 32'h40;
        update_pc = 32'h84;
        update_target = 32'h700;
        update_mispred = 1'b1;
        #2 chk("pre-reset hit", {31'd0, pred_hit}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("async cnt", {28'd0, mispred_count}, 32'd0);
        chk("async hit", {31'd0, pred_hit}, 32'd0);
        chk("async npc", pred_npc, 32'h44);
        for (int k = 0; k < 16; k++) begin
            lookup_pc = 32'h40 + 32'(k * 4);
            #1 chk($sformatf("async miss %0d", k), {31'd0, pred_hit}, 32'd0);
        end
        @(negedge CLK);
        idle();
        nRST = 1'b1;
        lookup_pc = 32'h84;
        #2;
        chk("post-reset miss", {31'd0, pred_hit}, 32'd0);
        chk("post-reset cnt", {28'd0, mispred_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
